// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the BRISC-V datapath.
// It walks each instruction through FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB]. It also
// gates the state-changing strobes: IR load, PC commit, register write and memory requests.
// Memory accesses use a req/ready handshake, so variable-latency memories simply stall.
// Optional feature: define PERF_COUNTERS_EN to enable the cycle and instret counters.
// Otherwise both counter ports are tied to 0.
module multicycle_sequencer #(
    parameter int unsigned CORE      = 0,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic [6:0]           opcode,
    input  logic                 i_mem_ready,
    input  logic                 d_mem_ready,
    output logic                 i_mem_req,
    output logic                 d_mem_req,
    output logic                 d_mem_we,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 illegal,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpR       = 7'b0110011;
    localparam logic [6:0] OpI       = 7'b0010011;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpFence   = 7'b0001111;
    localparam logic [6:0] OpSyscall = 7'b1110011;

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExecute = 3'd2,
        StMem     = 3'd3,
        StWb      = 3'd4,
        StHalt    = 3'd5
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    // CORE is identification only; it has no effect on the logic.
    logic unused_core;
    assign unused_core = ^CORE;

    // State and sticky illegal-opcode flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and Moore/handshake strobes decoded straight from state, opcode and ready.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        i_mem_req = 1'b0;
        d_mem_req = 1'b0;
        d_mem_we  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        unique case (state_q)
            StFetch: begin
                i_mem_req = run;
                if (run && i_mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: state_d = StExecute;
            StExecute: begin
                unique case (opcode)
                    OpLoad, OpStore: state_d = StMem;
                    OpR, OpI, OpJal, OpJalr, OpAuipc, OpLui: state_d = StWb;
                    OpBranch, OpFence, OpSyscall: begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = StHalt;
                    end
                endcase
            end
            StMem: begin
                d_mem_req = 1'b1;
                d_mem_we  = (opcode == OpStore);
                if (d_mem_ready) begin
                    // Stores retire on the ready cycle; loads still need a writeback.
                    if (opcode == OpStore) begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    assign illegal = illegal_q;
    assign state   = state_q;

`ifdef PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] cycle_q, instret_q;

    // Free-running performance counters; cycles freeze once halted, both wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != StHalt) cycle_q <= cycle_q + CNT_WIDTH'(1);
            if (pc_write) instret_q <= instret_q + CNT_WIDTH'(1);
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer.
// Inputs change and outputs are checked shortly after the falling edge, away from the
// rising edge. Cycle cN is the N-th cycle after the one in which the fetch begins.
module tb_multicycle_sequencer;

    localparam int unsigned W = 32;
`ifdef PERF_COUNTERS_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         run = 1'b0;
    logic [6:0]   opcode = 7'd0;
    logic         i_mem_ready = 1'b0;
    logic         d_mem_ready = 1'b0;
    logic         i_mem_req, d_mem_req, d_mem_we, ir_write, pc_write, reg_write, illegal;
    logic [2:0]   state;
    logic [W-1:0] cycle_count, instret_count;

    int passed = 0;
    int total  = 0;

    multicycle_sequencer #(.CORE(0), .CNT_WIDTH(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .opcode        (opcode),
        .i_mem_ready   (i_mem_ready),
        .d_mem_ready   (d_mem_ready),
        .i_mem_req     (i_mem_req),
        .d_mem_req     (d_mem_req),
        .d_mem_we      (d_mem_we),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .illegal       (illegal),
        .state         (state),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] cnt(input int unsigned v);
        return Perf ? W'(v) : '0;
    endfunction

    // Advance one cycle and settle just after the falling edge.
    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; run = 1'b0; opcode = 7'd0; i_mem_ready = 1'b0; d_mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (state !== 3'd0) $display("FAIL rst_state got %0d want 0", state); else passed++;
        total++; if ({i_mem_req, d_mem_req, ir_write, pc_write, reg_write, illegal} !== 6'b0)
            $display("FAIL rst_strobes got %b want 000000",
                     {i_mem_req, d_mem_req, ir_write, pc_write, reg_write, illegal});
        else passed++;
        total++; if (cycle_count !== '0 || instret_count !== '0)
            $display("FAIL rst_counters got %0d/%0d want 0/0", cycle_count, instret_count);
        else passed++;
    endtask

    task automatic test_rtype();
        do_reset();
        run = 1'b1; i_mem_ready = 1'b1; d_mem_ready = 1'b1; opcode = 7'b0110011; #1;
        total++; if ({i_mem_req, ir_write} !== 2'b11)
            $display("FAIL r_c0_fetch got %b want 11", {i_mem_req, ir_write}); else passed++;
        next_cycle();
        total++; if (state !== 3'd1 || ir_write !== 1'b0)
            $display("FAIL r_c1 got state %0d irw %b want 1 0", state, ir_write); else passed++;
        next_cycle();
        total++; if (state !== 3'd2 || pc_write !== 1'b0)
            $display("FAIL r_c2 got state %0d pcw %b want 2 0", state, pc_write); else passed++;
        next_cycle();
        total++; if ({state, reg_write, pc_write, ir_write} !== {3'd4, 3'b110})
            $display("FAIL r_c3_wb got %b want 100110", {state, reg_write, pc_write, ir_write});
        else passed++;
        next_cycle();
        total++; if (state !== 3'd0 || i_mem_req !== 1'b1)
            $display("FAIL r_c4_fetch got state %0d req %b want 0 1", state, i_mem_req);
        else passed++;
        total++; if (cycle_count !== cnt(4) || instret_count !== cnt(1))
            $display("FAIL r_c4_counters got %0d/%0d want %0d/%0d",
                     cycle_count, instret_count, cnt(4), cnt(1));
        else passed++;
    endtask

    task automatic test_load_wait();
        int req_cycles = 0;
        do_reset();
        run = 1'b1; i_mem_ready = 1'b1; d_mem_ready = 1'b0; opcode = 7'b0000011; #1;
        next_cycle(); next_cycle(); next_cycle();  // now c3, first MEM cycle
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin d_mem_ready = 1'b1; #1; end
            if (d_mem_req === 1'b1 && d_mem_we === 1'b0 && state === 3'd3) req_cycles++;
            next_cycle();
        end
        total++; if (req_cycles != 3)
            $display("FAIL ld_req_cycles got %0d want 3", req_cycles); else passed++;
        total++; if (state !== 3'd4 || reg_write !== 1'b1 || d_mem_req !== 1'b0)
            $display("FAIL ld_c6_wb got state %0d rw %b dreq %b want 4 1 0",
                     state, reg_write, d_mem_req);
        else passed++;
        run = 1'b0; next_cycle();
        total++; if (state !== 3'd0 || cycle_count !== cnt(7) || instret_count !== cnt(1))
            $display("FAIL ld_c7 got state %0d cyc %0d ret %0d want 0 %0d %0d",
                     state, cycle_count, instret_count, cnt(7), cnt(1));
        else passed++;
    endtask

    task automatic test_store();
        bit saw_rw = 1'b0;
        do_reset();
        run = 1'b1; i_mem_ready = 1'b1; d_mem_ready = 1'b1; opcode = 7'b0100011; #1;
        for (int i = 0; i < 3; i++) begin
            if (reg_write === 1'b1) saw_rw = 1'b1;
            next_cycle();
        end
        total++; if ({state, d_mem_req, d_mem_we, pc_write} !== {3'd3, 3'b111})
            $display("FAIL st_c3 got %b want 011111", {state, d_mem_req, d_mem_we, pc_write});
        else passed++;
        if (reg_write === 1'b1) saw_rw = 1'b1;
        next_cycle();
        if (reg_write === 1'b1) saw_rw = 1'b1;
        total++; if (saw_rw !== 1'b0) $display("FAIL st_no_regwrite got 1 want 0"); else passed++;
        total++; if (state !== 3'd0 || instret_count !== cnt(1))
            $display("FAIL st_c4 got state %0d ret %0d want 0 %0d", state, instret_count, cnt(1));
        else passed++;
    endtask

    task automatic test_branch_back_to_back();
        do_reset();
        run = 1'b1; i_mem_ready = 1'b1; opcode = 7'b1100011; #1;
        next_cycle(); next_cycle();
        total++; if (state !== 3'd2 || pc_write !== 1'b1)
            $display("FAIL br_c2 got state %0d pcw %b want 2 1", state, pc_write); else passed++;
        next_cycle();
        total++; if (state !== 3'd0 || ir_write !== 1'b1)
            $display("FAIL br_c3_refetch got state %0d irw %b want 0 1", state, ir_write);
        else passed++;
        opcode = 7'b0001111;
        next_cycle(); next_cycle(); next_cycle();
        total++; if (cycle_count !== cnt(6) || instret_count !== cnt(2))
            $display("FAIL br_b2b_counters got %0d/%0d want %0d/%0d",
                     cycle_count, instret_count, cnt(6), cnt(2));
        else passed++;
    endtask

    task automatic test_illegal();
        bit saw_req = 1'b0;
        do_reset();
        run = 1'b1; i_mem_ready = 1'b1; opcode = 7'b0000000; #1;
        next_cycle(); next_cycle();
        total++; if (pc_write !== 1'b0) $display("FAIL ill_pcw got 1 want 0"); else passed++;
        next_cycle();
        total++; if (state !== 3'd5 || illegal !== 1'b1)
            $display("FAIL ill_halt got state %0d ill %b want 5 1", state, illegal); else passed++;
        for (int i = 0; i < 20; i++) begin
            if (i_mem_req !== 1'b0 || state !== 3'd5) saw_req = 1'b1;
            next_cycle();
        end
        total++; if (saw_req !== 1'b0) $display("FAIL ill_stuck got 1 want 0"); else passed++;
        total++; if (cycle_count !== cnt(3))
            $display("FAIL ill_cycle_frozen got %0d want %0d", cycle_count, cnt(3)); else passed++;
        do_reset();
        total++; if (illegal !== 1'b0 || state !== 3'd0)
            $display("FAIL ill_reset got ill %b state %0d want 0 0", illegal, state); else passed++;
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        run = 1'b1; i_mem_ready = 1'b1; d_mem_ready = 1'b0; opcode = 7'b0000011; #1;
        next_cycle(); next_cycle(); next_cycle();
        total++; if (d_mem_req !== 1'b1) $display("FAIL rm_req_before got 0 want 1"); else passed++;
        #1 reset = 1'b0; #1;
        total++; if (d_mem_req !== 1'b0 || state !== 3'd0)
            $display("FAIL rm_async got dreq %b state %0d want 0 0", d_mem_req, state);
        else passed++;
        total++; if (cycle_count !== '0 || instret_count !== '0)
            $display("FAIL rm_counters got %0d/%0d want 0/0", cycle_count, instret_count);
        else passed++;
        @(negedge clock); reset = 1'b1; #1;
    endtask

    task automatic test_run_drop();
        do_reset();
        run = 1'b1; i_mem_ready = 1'b1; opcode = 7'b0110011; #1;
        next_cycle(); next_cycle();
        run = 1'b0; #1;
        next_cycle();
        total++; if (state !== 3'd4 || pc_write !== 1'b1)
            $display("FAIL rd_wb got state %0d pcw %b want 4 1", state, pc_write); else passed++;
        for (int i = 0; i < 4; i++) next_cycle();
        total++; if (state !== 3'd0 || i_mem_req !== 1'b0)
            $display("FAIL rd_parked got state %0d req %b want 0 0", state, i_mem_req);
        else passed++;
        run = 1'b1; #1;
        total++; if (i_mem_req !== 1'b1 || ir_write !== 1'b1)
            $display("FAIL rd_resume got req %b irw %b want 1 1", i_mem_req, ir_write);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_branch_back_to_back();
        test_illegal();
        test_reset_mid_mem();
        test_run_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
